// File: rtl/ulpi_reg_arbiter_pkg.sv
// Shared ULPI register-access definitions: register addresses, function-control
// patterns and the arbiter state encoding.
package ulpi_pkg;

  // ULPI register addresses
  localparam logic [5:0] FUN_CTRL = 6'h04;
  localparam logic [5:0] OTG_CTRL = 6'h0A;
  localparam logic [5:0] SCRATCH  = 6'h16;

  // Function-control write patterns used during link bring-up
  localparam logic [7:0] FUN_CTRL_FS_START = 8'b01100101;
  localparam logic [7:0] FUN_CTRL_CHIRP    = 8'b01010100;
  localparam logic [7:0] FUN_CTRL_HS_IDLE  = 8'b01000000;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StBackoff,
    StRespOk,
    StRespFail
  } arb_state_e;

  // Saturating 8-bit increment
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ulpi_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// scanning upward with wrap.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  // Scan from the pointer; the first hit wins
  always_comb begin : pick
    logic [IdxW-1:0] j;
    j       = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = IdxW'((32'(ptr_i) + k) % N_REQ);
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        idx_o      = j;
        grant_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter sharing the ULPI register-access port between N_REQ
// clients, with retry/backoff and a response timeout. All outputs registered.
module ulpi_reg_arbiter
  import ulpi_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned BACKOFF_CYC = 4
) (
  input  logic               CLK_60M,
  input  logic               RST_A_USB,
  input  logic [N_REQ-1:0]   REQ_VALID,
  input  logic [N_REQ-1:0]   REQ_RW,
  input  logic [6*N_REQ-1:0] REQ_ADDR,
  input  logic [8*N_REQ-1:0] REQ_WDATA,
  output logic [N_REQ-1:0]   REQ_DONE,
  output logic [N_REQ-1:0]   REQ_FAIL,
  output logic [7:0]         RD_DATA,
  input  logic               ULPI_READY,
  output logic               REG_EN,
  output logic               REG_RW,
  output logic [5:0]         REG_ADDR,
  output logic [7:0]         REG_DATA_I,
  input  logic [7:0]         REG_DATA_O,
  input  logic               REG_DONE,
  input  logic               REG_FAIL,
  output logic [N_REQ-1:0]   GRANT,
  output logic               BUSY,
  output logic [7:0]         ERR_CNT
);

  localparam int unsigned IdxW    = $clog2(N_REQ);
  localparam logic [15:0] ToLast  = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] BoLast  = 16'(BACKOFF_CYC - 1);
  localparam logic [3:0]  RetryMx = 4'(MAX_RETRY);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d, idx_q, idx_d;
  logic [3:0]       retry_q, retry_d;
  logic [15:0]      timer_q, timer_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             rw_q, rw_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rd_q, rd_d;
  logic [7:0]       err_q, err_d;
  logic             reg_en_q, reg_en_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] done_q, done_d, fail_q, fail_d;

  logic [N_REQ-1:0] pick_grant;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .valid_i (REQ_VALID),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Next-state logic; registered outputs are derived from the next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    timer_d = timer_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (ULPI_READY && pick_any) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          retry_d = '0;
          for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_grant[i]) begin
              rw_d    = REQ_RW[i];
              addr_d  = REQ_ADDR[6*i +: 6];
              wdata_d = REQ_WDATA[8*i +: 8];
            end
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 16'd1;
        // DONE takes priority over a simultaneous FAIL
        if (REG_DONE) begin
          if (!rw_q) rd_d = REG_DATA_O;
          state_d = StRespOk;
        end else if (REG_FAIL || !ULPI_READY || timer_q == ToLast) begin
          timer_d = '0;
          if (retry_q < RetryMx) begin
            retry_d = retry_q + 4'd1;
            state_d = StBackoff;
          end else begin
            err_d   = sat_inc8(err_q);
            state_d = StRespFail;
          end
        end
      end
      StBackoff: begin
        // Hold after the backoff count until the PHY is ready again
        if (timer_q >= BoLast) begin
          if (ULPI_READY) state_d = StIssue;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StRespOk, StRespFail: begin
        ptr_d   = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    reg_en_d = (state_d == StIssue);
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StRespOk)   ? grant_q : '0;
    fail_d   = (state_d == StRespFail) ? grant_q : '0;
  end

  // State and output registers; reset aborts any transaction immediately
  always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
    if (RST_A_USB) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      idx_q    <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      grant_q  <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= '0;
      reg_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      reg_en_q <= reg_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign REQ_DONE   = done_q;
  assign REQ_FAIL   = fail_q;
  assign RD_DATA    = rd_q;
  assign REG_EN     = reg_en_q;
  assign REG_RW     = rw_q;
  assign REG_ADDR   = addr_q;
  assign REG_DATA_I = wdata_q;
  assign GRANT      = grant_q;
  assign BUSY       = busy_q;
  assign ERR_CNT    = err_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: scripted ULPI PHY responder, requester agents
// and a transaction-level reference model.
`timescale 1ns/1ps
module tb_ulpi_reg_arbiter;
  import ulpi_pkg::*;

  localparam int N  = 4;
  localparam int MR = 3;
  localparam int TO = 16;
  localparam int BO = 4;
  localparam int KDone = 0, KFail = 1, KNone = 2, KBoth = 3;

  logic           CLK_60M = 1'b0;
  logic           RST_A_USB;
  logic [N-1:0]   REQ_VALID, REQ_RW, REQ_DONE, REQ_FAIL, GRANT;
  logic [6*N-1:0] REQ_ADDR;
  logic [8*N-1:0] REQ_WDATA;
  logic [7:0]     RD_DATA, REG_DATA_I, REG_DATA_O, ERR_CNT;
  logic           ULPI_READY, REG_EN, REG_RW, REG_DONE, REG_FAIL, BUSY;
  logic [5:0]     REG_ADDR;

  ulpi_reg_arbiter #(
    .N_REQ       (N),
    .MAX_RETRY   (MR),
    .TIMEOUT_CYC (TO),
    .BACKOFF_CYC (BO)
  ) dut (
    .CLK_60M    (CLK_60M),
    .RST_A_USB  (RST_A_USB),
    .REQ_VALID  (REQ_VALID),
    .REQ_RW     (REQ_RW),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .REQ_DONE   (REQ_DONE),
    .REQ_FAIL   (REQ_FAIL),
    .RD_DATA    (RD_DATA),
    .ULPI_READY (ULPI_READY),
    .REG_EN     (REG_EN),
    .REG_RW     (REG_RW),
    .REG_ADDR   (REG_ADDR),
    .REG_DATA_I (REG_DATA_I),
    .REG_DATA_O (REG_DATA_O),
    .REG_DONE   (REG_DONE),
    .REG_FAIL   (REG_FAIL),
    .GRANT      (GRANT),
    .BUSY       (BUSY),
    .ERR_CNT    (ERR_CNT)
  );

  always #5 CLK_60M = ~CLK_60M;

  typedef struct packed { int kind; int lat; logic [7:0] data; } att_t;
  typedef struct packed { int cyc; logic rw; logic [5:0] addr; logic [7:0] data; } iss_t;
  typedef struct packed { int cyc; int req; logic ok; logic [7:0] rd; } rsp_t;

  att_t plan_q[$];
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int   total = 0, bad = 0, cyc = 0;
  bit   phy_armed = 0;
  int   phy_at;
  att_t phy_a;
  int   exp_err, m_ptr;
  logic [7:0] exp_rd;

  task automatic set_cmd(input int i, input logic rw, input logic [5:0] addr,
                         input logic [7:0] data);
    REQ_RW[i]            = rw;
    REQ_ADDR[6*i +: 6]   = addr;
    REQ_WDATA[8*i +: 8]  = data;
  endtask

  // One clock: sample just after the edge, then drive PHY and requesters
  task automatic tick();
    @(posedge CLK_60M);
    #1;
    cyc++;
    REG_DONE   = 1'b0;
    REG_FAIL   = 1'b0;
    REG_DATA_O = 8'($urandom);
    if (REG_EN === 1'b1) begin
      iss_q.push_back('{cyc, REG_RW, REG_ADDR, REG_DATA_I});
      if (plan_q.size() > 0) phy_a = plan_q.pop_front();
      else phy_a = '{KDone, 2, 8'($urandom)};
      if (phy_a.kind != KNone) begin
        phy_armed = 1;
        phy_at    = cyc + phy_a.lat;
      end
    end
    if (phy_armed && cyc == phy_at) begin
      phy_armed = 0;
      REG_DONE  = (phy_a.kind == KDone || phy_a.kind == KBoth);
      REG_FAIL  = (phy_a.kind == KFail || phy_a.kind == KBoth);
      if (REG_DONE) REG_DATA_O = phy_a.data;
    end
    if ((REQ_DONE | REQ_FAIL) !== '0) begin
      total++;
      if ((REQ_DONE | REQ_FAIL) !== GRANT || (REQ_DONE & REQ_FAIL) !== '0) begin
        bad++;
        $display("FAIL resp_owner: done=%b fail=%b grant=%b", REQ_DONE, REQ_FAIL, GRANT);
      end
      for (int i = 0; i < N; i++) begin
        if (REQ_DONE[i] || REQ_FAIL[i]) begin
          rsp_q.push_back('{cyc, i, REQ_DONE[i], RD_DATA});
          REQ_VALID[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic apply_reset();
    RST_A_USB  = 1'b1;
    REQ_VALID  = '0;
    REG_DONE   = 1'b0;
    REG_FAIL   = 1'b0;
    ULPI_READY = 1'b1;
    phy_armed  = 0;
    plan_q.delete();
    repeat (3) @(posedge CLK_60M);
    #1;
    RST_A_USB = 1'b0;
    exp_err   = 0;
    exp_rd    = 8'h00;
    m_ptr     = 0;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (rsp_q.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: responses got %0d need %0d", name, rsp_q.size(), n);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    rsp_q.delete();
  endtask

  task automatic test_reset();
    RST_A_USB  = 1'b1;
    REQ_VALID  = '1;
    REQ_RW     = '1;
    REQ_ADDR   = '1;
    REQ_WDATA  = '1;
    ULPI_READY = 1'b1;
    REG_DONE   = 1'b0;
    REG_FAIL   = 1'b0;
    REG_DATA_O = 8'hFF;
    repeat (2) @(posedge CLK_60M);
    #1;
    total++; if (REG_EN !== 1'b0) begin bad++; $display("FAIL rst_reg_en: got %b want 0", REG_EN); end
    total++; if (GRANT !== '0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rst_grant_busy: got %b/%b want 0/0", GRANT, BUSY); end
    total++; if ((REQ_DONE | REQ_FAIL) !== '0) begin
      bad++; $display("FAIL rst_resp: got %b/%b want 0", REQ_DONE, REQ_FAIL); end
    total++; if (RD_DATA !== 8'h00 || ERR_CNT !== 8'h00) begin
      bad++; $display("FAIL rst_rd_err: got %h/%h want 00/00", RD_DATA, ERR_CNT); end
    total++; if ({REG_RW, REG_ADDR, REG_DATA_I} !== 15'h0) begin
      bad++; $display("FAIL rst_cmd: got %b %h %h want 0", REG_RW, REG_ADDR, REG_DATA_I); end
    REQ_VALID = '0;
    RST_A_USB = 1'b0;
    exp_err = 0; exp_rd = 8'h00; m_ptr = 0;
    tick();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_idle: busy=%b want 0", BUSY); end
  endtask

  task automatic test_single_write();
    clear_logs();
    set_cmd(1, 1'b1, FUN_CTRL, FUN_CTRL_FS_START);
    plan_q.push_back('{KDone, 5, 8'h00});
    REQ_VALID[1] = 1'b1;
    wait_rsp(1, 40, "single_write");
    tick();
    total++; if (iss_q.size() !== 1) begin
      bad++; $display("FAIL wr_en_count: got %0d want 1", iss_q.size()); end
    if (iss_q.size() > 0 && rsp_q.size() > 0) begin
      total++; if ({iss_q[0].rw, iss_q[0].addr, iss_q[0].data} !== {1'b1, 6'h04, 8'h65}) begin
        bad++; $display("FAIL wr_cmd: got %b %h %h want 1 04 65",
                        iss_q[0].rw, iss_q[0].addr, iss_q[0].data); end
      total++; if (rsp_q[0].req !== 1 || rsp_q[0].ok !== 1'b1) begin
        bad++; $display("FAIL wr_resp: got req %0d ok %b want 1 1", rsp_q[0].req, rsp_q[0].ok); end
      total++; if (rsp_q[0].cyc - iss_q[0].cyc !== 6) begin
        bad++; $display("FAIL wr_latency: got %0d want 6", rsp_q[0].cyc - iss_q[0].cyc); end
    end
    total++; if (GRANT !== '0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL wr_release: got %b/%b want 0/0", GRANT, BUSY); end
  endtask

  task automatic test_read_hold();
    clear_logs();
    set_cmd(2, 1'b0, SCRATCH, 8'h3C);
    plan_q.push_back('{KDone, 3, 8'h55});
    REQ_VALID[2] = 1'b1;
    wait_rsp(1, 40, "read");
    set_cmd(0, 1'b1, SCRATCH, 8'hA5);
    plan_q.push_back('{KDone, 2, 8'hEE});
    REQ_VALID[0] = 1'b1;
    wait_rsp(2, 40, "read_then_write");
    repeat (3) tick();
    if (rsp_q.size() == 2) begin
      total++; if (rsp_q[0].rd !== 8'h55 || rsp_q[0].req !== 2) begin
        bad++; $display("FAIL rd_data: got %h req %0d want 55 req 2", rsp_q[0].rd, rsp_q[0].req); end
      total++; if (rsp_q[1].rd !== 8'h55) begin
        bad++; $display("FAIL rd_after_write: got %h want 55", rsp_q[1].rd); end
    end
    total++; if (RD_DATA !== 8'h55) begin
      bad++; $display("FAIL rd_hold: got %h want 55", RD_DATA); end
  endtask

  task automatic test_rr_order();
    int  exp_order[5];
    bit  again;
    int  k;
    exp_order = '{0, 1, 2, 3, 0};
    apply_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, SCRATCH, 8'(i));
    REQ_VALID = '1;
    again = 0;
    k = 0;
    while (rsp_q.size() < 5 && k < 300) begin
      tick();
      k++;
      if (!again && GRANT === 4'b0100) begin
        REQ_VALID[0] = 1'b1;
        again = 1;
      end
    end
    total++; if (rsp_q.size() !== 5) begin
      bad++; $display("FAIL rr_count: got %0d want 5", rsp_q.size()); end
    for (int j = 0; j < 5 && j < rsp_q.size(); j++) begin
      total++; if (rsp_q[j].req !== exp_order[j]) begin
        bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", j, rsp_q[j].req, exp_order[j]); end
    end
  endtask

  task automatic test_retry_fail();
    clear_logs();
    set_cmd(3, 1'b1, OTG_CTRL, 8'h21);
    for (int a = 0; a <= MR; a++) plan_q.push_back('{KFail, 2, 8'h00});
    REQ_VALID[3] = 1'b1;
    wait_rsp(1, 200, "retry_fail");
    exp_err++;
    tick();
    total++; if (iss_q.size() !== MR + 1) begin
      bad++; $display("FAIL retry_en_count: got %0d want %0d", iss_q.size(), MR + 1); end
    for (int j = 1; j < iss_q.size(); j++) begin
      total++; if (iss_q[j].cyc - iss_q[j-1].cyc !== 2 + BO + 1) begin
        bad++; $display("FAIL retry_gap[%0d]: got %0d want %0d", j,
                        iss_q[j].cyc - iss_q[j-1].cyc, 2 + BO + 1); end
    end
    if (rsp_q.size() > 0) begin
      total++; if (rsp_q[0].ok !== 1'b0 || rsp_q[0].req !== 3) begin
        bad++; $display("FAIL retry_resp: got ok %b req %0d want 0 3", rsp_q[0].ok, rsp_q[0].req); end
    end
    total++; if (ERR_CNT !== 8'(exp_err)) begin
      bad++; $display("FAIL retry_err_cnt: got %0d want %0d", ERR_CNT, exp_err); end
  endtask

  task automatic test_timeout();
    clear_logs();
    set_cmd(1, 1'b0, SCRATCH, 8'h00);
    plan_q.push_back('{KNone, 0, 8'h00});
    plan_q.push_back('{KDone, 4, 8'h9A});
    REQ_VALID[1] = 1'b1;
    wait_rsp(1, 200, "timeout");
    set_cmd(2, 1'b0, FUN_CTRL, 8'h00);
    plan_q.push_back('{KBoth, 3, 8'hC3});
    REQ_VALID[2] = 1'b1;
    wait_rsp(2, 100, "done_and_fail");
    tick();
    total++; if (iss_q.size() !== 3) begin
      bad++; $display("FAIL to_en_count: got %0d want 3", iss_q.size()); end
    if (iss_q.size() >= 2) begin
      total++; if (iss_q[1].cyc - iss_q[0].cyc !== 1 + TO + BO) begin
        bad++; $display("FAIL to_gap: got %0d want %0d", iss_q[1].cyc - iss_q[0].cyc, 1 + TO + BO); end
    end
    if (rsp_q.size() == 2) begin
      total++; if (rsp_q[0].ok !== 1'b1 || rsp_q[0].rd !== 8'h9A) begin
        bad++; $display("FAIL to_resp: got ok %b rd %h want 1 9a", rsp_q[0].ok, rsp_q[0].rd); end
      total++; if (rsp_q[1].ok !== 1'b1 || rsp_q[1].rd !== 8'hC3) begin
        bad++; $display("FAIL both_resp: got ok %b rd %h want 1 c3", rsp_q[1].ok, rsp_q[1].rd); end
    end
    total++; if (ERR_CNT !== 8'(exp_err)) begin
      bad++; $display("FAIL to_err_cnt: got %0d want %0d", ERR_CNT, exp_err); end
  endtask

  task automatic test_ready_gate();
    int rise;
    clear_logs();
    ULPI_READY = 1'b0;
    set_cmd(0, 1'b1, FUN_CTRL, FUN_CTRL_CHIRP);
    REQ_VALID[0] = 1'b1;
    repeat (12) tick();
    total++; if (iss_q.size() !== 0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL ready_gate: issues %0d busy %b want 0 0", iss_q.size(), BUSY); end
    ULPI_READY = 1'b1;
    rise = cyc;
    wait_rsp(1, 40, "ready_gate");
    if (iss_q.size() > 0) begin
      total++; if (iss_q[0].cyc !== rise + 1) begin
        bad++; $display("FAIL ready_issue_cyc: got %0d want %0d", iss_q[0].cyc, rise + 1); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_logs();
    set_cmd(3, 1'b1, FUN_CTRL, FUN_CTRL_HS_IDLE);
    plan_q.push_back('{KDone, 8, 8'h00});
    REQ_VALID[3] = 1'b1;
    k = 0;
    while (iss_q.size() < 1 && k < 10) begin tick(); k++; end
    repeat (2) tick();
    #1 RST_A_USB = 1'b1;
    #1;
    total++; if ({REG_EN, BUSY, GRANT, REQ_DONE, REQ_FAIL} !== '0) begin
      bad++; $display("FAIL rst_mid_async: en %b busy %b grant %b done %b fail %b want 0",
                      REG_EN, BUSY, GRANT, REQ_DONE, REQ_FAIL); end
    total++; if (RD_DATA !== 8'h00 || ERR_CNT !== 8'h00) begin
      bad++; $display("FAIL rst_mid_regs: rd %h err %h want 00 00", RD_DATA, ERR_CNT); end
    REQ_VALID[3] = 1'b0;
    repeat (2) tick();
    RST_A_USB = 1'b0;
    exp_err = 0; exp_rd = 8'h00; m_ptr = 0;
    repeat (8) tick();
    total++; if (rsp_q.size() !== 0 || iss_q.size() !== 1 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: resps %0d issues %0d busy %b want 0 1 0",
                      rsp_q.size(), iss_q.size(), BUSY); end
  endtask

  task automatic test_random();
    iss_t e_iss[$];
    rsp_t e_rsp[$];
    apply_reset();
    for (int round = 0; round < 20; round++) begin
      logic [N-1:0] mask;
      int last;
      clear_logs();
      e_iss.delete();
      e_rsp.delete();
      mask = N'($urandom_range(1, (1 << N) - 1));
      last = m_ptr;
      for (int k = 0; k < N; k++) begin
        int g;
        g = (m_ptr + k) % N;
        if (mask[g]) begin
          logic rw;
          logic [5:0] addr;
          logic [7:0] wd;
          bit ok;
          rw   = 1'($urandom_range(0, 1));
          addr = 6'($urandom);
          wd   = 8'($urandom);
          set_cmd(g, rw, addr, wd);
          ok = 0;
          for (int a = 0; a <= MR && !ok; a++) begin
            att_t at;
            int r;
            r = int'($urandom_range(0, 5));
            at.kind = (r < 2) ? KDone : (r == 3) ? KNone : (r == 4) ? KBoth : KFail;
            at.lat  = int'($urandom_range(1, 8));
            at.data = 8'($urandom);
            plan_q.push_back(at);
            e_iss.push_back('{0, rw, addr, wd});
            if (at.kind == KDone || at.kind == KBoth) begin
              ok = 1;
              if (!rw) exp_rd = at.data;
            end
          end
          if (!ok && exp_err < 255) exp_err++;
          e_rsp.push_back('{0, g, ok, exp_rd});
          last = g;
        end
      end
      m_ptr = (last + 1) % N;
      REQ_VALID = mask;
      wait_rsp(e_rsp.size(), 600, "random");
      repeat (2) tick();
      total++; if (iss_q.size() !== e_iss.size() || rsp_q.size() !== e_rsp.size()) begin
        bad++; $display("FAIL rnd_counts[%0d]: issues %0d/%0d resps %0d/%0d", round,
                        iss_q.size(), e_iss.size(), rsp_q.size(), e_rsp.size()); end
      for (int j = 0; j < iss_q.size() && j < e_iss.size(); j++) begin
        total++;
        if ({iss_q[j].rw, iss_q[j].addr, iss_q[j].data} !==
            {e_iss[j].rw, e_iss[j].addr, e_iss[j].data}) begin
          bad++; $display("FAIL rnd_cmd[%0d.%0d]: got %b %h %h want %b %h %h", round, j,
                          iss_q[j].rw, iss_q[j].addr, iss_q[j].data,
                          e_iss[j].rw, e_iss[j].addr, e_iss[j].data); end
      end
      for (int j = 0; j < rsp_q.size() && j < e_rsp.size(); j++) begin
        total++;
        if (rsp_q[j].req !== e_rsp[j].req || rsp_q[j].ok !== e_rsp[j].ok ||
            rsp_q[j].rd !== e_rsp[j].rd) begin
          bad++; $display("FAIL rnd_resp[%0d.%0d]: got req %0d ok %b rd %h want %0d %b %h",
                          round, j, rsp_q[j].req, rsp_q[j].ok, rsp_q[j].rd,
                          e_rsp[j].req, e_rsp[j].ok, e_rsp[j].rd); end
      end
      total++; if (ERR_CNT !== 8'(exp_err)) begin
        bad++; $display("FAIL rnd_err_cnt[%0d]: got %0d want %0d", round, ERR_CNT, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_hold();
    test_rr_order();
    test_retry_fail();
    test_timeout();
    test_ready_gate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
